// File: rtl/load_align_queue_if.sv
// Handshake bundle between the M-stage load path, the data-memory response and writeback
// for load_align_queue. The master side is the pipeline/memory, the slave side is the queue.
interface load_align_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [1:0]       req_off;
    logic [31:0]      req_rt;
    logic [TAG_W-1:0] req_tag;

    logic             rsp_valid;
    logic [31:0]      rsp_data;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [CNT_W-1:0] occupancy;

    modport master (
        output req_valid, req_op, req_off, req_rt, req_tag,
        output rsp_valid, rsp_data,
        output out_ready,
        input  req_ready, out_valid, out_data, out_tag, out_err, occupancy
    );

    modport slave (
        input  req_valid, req_op, req_off, req_rt, req_tag,
        input  rsp_valid, rsp_data,
        input  out_ready,
        output req_ready, out_valid, out_data, out_tag, out_err, occupancy
    );
endinterface

// File: rtl/load_align_queue.sv
// In-order load-result queue: matches variable-latency memory responses to tracked loads,
// extracts/extends/merges the result and drops responses belonging to flushed loads.
module load_align_queue #(
    parameter int DEPTH      = 4,
    parameter int TAG_W      = 5,
    parameter int BIG_ENDIAN = 1,
    parameter int LWLR_EN    = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               flush,
    load_align_queue_if.slave  bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int DROP_W = CNT_W + 1;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_LWL = 3'd5;
    localparam logic [2:0] OP_LWR = 3'd6;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ok;
    logic [DEPTH-1:0]  r_err;
    logic [2:0]        r_op   [DEPTH];
    logic [1:0]        r_off  [DEPTH];
    logic [31:0]       r_rt   [DEPTH];
    logic [31:0]       r_data [DEPTH];
    logic [TAG_W-1:0]  r_tag  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [DROP_W-1:0] r_drop;

    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [2:0]        w_req_op;
    logic              w_req_err;
    logic              w_await_found;
    logic [PTR_W-1:0]  w_await_idx;
    logic [CNT_W-1:0]  w_await_cnt;
    logic              w_rsp_drop;
    logic              w_rsp_take;
    logic [DROP_W-1:0] w_drop_next;

    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign bus.req_ready = ~w_full & ~flush;
    assign w_push        = bus.req_valid & bus.req_ready;
    assign w_pop         = bus.out_valid & bus.out_ready;

    // Reserved op 7, and LWL/LWR when unsupported, are stored as plain LW.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_req_op = bus.req_op;
        if (bus.req_op == 3'd7 ||
            (LWLR_EN == 0 && (bus.req_op == OP_LWL || bus.req_op == OP_LWR)))
            w_req_op = OP_LW;
        w_req_err = ((w_req_op == OP_LH || w_req_op == OP_LHU) && bus.req_off[0]) ||
                    (w_req_op == OP_LW && bus.req_off != 2'd0);
    end

    // Walk from the head so the first hit is the oldest entry still waiting for memory.
    always_comb begin
        w_await_found = 1'b0;
        w_await_idx   = '0;
        w_await_cnt   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[r_head + PTR_W'(i)] && !r_err[r_head + PTR_W'(i)] &&
                !r_ok[r_head + PTR_W'(i)]) begin
                w_await_cnt = w_await_cnt + CNT_W'(1);
                if (!w_await_found) begin
                    w_await_found = 1'b1;
                    w_await_idx   = r_head + PTR_W'(i);
                end
            end
        end
    end

    assign w_rsp_drop = bus.rsp_valid & (r_drop != '0);
    assign w_rsp_take = bus.rsp_valid & ~w_rsp_drop & w_await_found;

    // A response consumed in the flush cycle no longer counts as awaiting.
    always_comb begin
        w_drop_next = r_drop - DROP_W'(w_rsp_drop);
        if (flush)
            w_drop_next = w_drop_next + DROP_W'(w_await_cnt) - DROP_W'(w_rsp_take);
    end

    // NOTE: payload storage is deliberately not reset; r_valid/r_ok gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op[r_tail]  <= w_req_op;
            r_off[r_tail] <= bus.req_off;
            r_rt[r_tail]  <= bus.req_rt;
            r_tag[r_tail] <= bus.req_tag;
        end
        if (w_rsp_take)
            r_data[w_await_idx] <= bus.rsp_data;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!resetn) begin
            r_valid <= '0;
            r_ok    <= '0;
            r_err   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ok    <= '0;
            r_err   <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_drop  <= w_drop_next;
        end else begin
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_ok[r_tail]    <= 1'b0;
                r_err[r_tail]   <= w_req_err;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_rsp_take)
                r_ok[w_await_idx] <= 1'b1;
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_drop <= w_drop_next;
        end
    end

    logic [31:0] w_mem;
    logic [31:0] w_rt;
    logic [1:0]  w_k;
    logic        w_hsel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_result;
    logic        w_head_valid;

    assign w_head_valid = r_valid[r_head];
    assign w_mem        = r_data[r_head];
    assign w_rt         = r_rt[r_head];
    // k is the byte position in big-endian numbering: 0 is bits [31:24].
    assign w_k          = (BIG_ENDIAN != 0) ? r_off[r_head] : ~r_off[r_head];
    assign w_hsel       = w_k[1];

    always_comb begin
        w_byte = w_mem[7:0];
        case (w_k)
            2'd0:    w_byte = w_mem[31:24];
            2'd1:    w_byte = w_mem[23:16];
            2'd2:    w_byte = w_mem[15:8];
            default: w_byte = w_mem[7:0];
        endcase
        w_half = w_hsel ? w_mem[15:0] : w_mem[31:16];

        w_result = w_mem;
        case (r_op[r_head])
            OP_LB:  w_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU: w_result = {24'd0, w_byte};
            OP_LH:  w_result = {{16{w_half[15]}}, w_half};
            OP_LHU: w_result = {16'd0, w_half};
            OP_LWL: begin
                case (w_k)
                    2'd0:    w_result = w_mem;
                    2'd1:    w_result = {w_mem[23:0], w_rt[7:0]};
                    2'd2:    w_result = {w_mem[15:0], w_rt[15:0]};
                    default: w_result = {w_mem[7:0],  w_rt[23:0]};
                endcase
            end
            OP_LWR: begin
                case (w_k)
                    2'd0:    w_result = {w_rt[31:8],  w_mem[31:24]};
                    2'd1:    w_result = {w_rt[31:16], w_mem[31:16]};
                    2'd2:    w_result = {w_rt[31:24], w_mem[31:8]};
                    default: w_result = w_mem;
                endcase
            end
            default: w_result = w_mem;
        endcase
    end

    assign bus.out_valid = w_head_valid & (r_err[r_head] | r_ok[r_head]);
    assign bus.out_err   = w_head_valid & r_err[r_head];
    assign bus.out_tag   = w_head_valid ? r_tag[r_head] : '0;
    assign bus.out_data  = (bus.out_valid && !r_err[r_head]) ? w_result : 32'd0;
    assign bus.occupancy = r_count;
endmodule
